// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: bundles the ID/EX-side inputs, the MEM-side handshake
// and the registered EX/MEM outputs of the execute stage.
// The "slave" modport is the execute stage itself; "master" is its
// surroundings (ID/EX register on one side, MEM stage on the other).
interface ex_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // ID/EX side
  logic                  id_valid;
  logic                  id_ready;
  logic                  id_flush;
  logic [2:0]            id_alu_ctrl;
  logic [DATA_W-1:0]     id_operand_a;
  logic [DATA_W-1:0]     id_operand_b;
  logic [DATA_W-1:0]     id_store_data;
  logic [DATA_W-1:0]     id_branch_target;
  logic [REG_ADDR_W-1:0] id_dest_reg;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_branch;

  // EX/MEM side
  logic                  ex_valid;
  logic                  mem_ready;
  logic [DATA_W-1:0]     ex_result;
  logic                  ex_zero;
  logic [DATA_W-1:0]     ex_store_data;
  logic [DATA_W-1:0]     ex_branch_target;
  logic [REG_ADDR_W-1:0] ex_dest_reg;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch_taken;
  logic                  ex_overflow;

  modport slave (
    input  id_valid, id_flush, id_alu_ctrl, id_operand_a, id_operand_b,
           id_store_data, id_branch_target, id_dest_reg,
           id_reg_write, id_mem_read, id_mem_write, id_branch,
           mem_ready,
    output id_ready, ex_valid, ex_result, ex_zero, ex_store_data,
           ex_branch_target, ex_dest_reg, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch_taken, ex_overflow
  );

  modport master (
    output id_valid, id_flush, id_alu_ctrl, id_operand_a, id_operand_b,
           id_store_data, id_branch_target, id_dest_reg,
           id_reg_write, id_mem_read, id_mem_write, id_branch,
           mem_ready,
    input  id_ready, ex_valid, ex_result, ex_zero, ex_store_data,
           ex_branch_target, ex_dest_reg, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch_taken, ex_overflow
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS execute stage (ALU, zero flag, BEQ resolution) and the
// EX/MEM pipeline register behind a valid/ready handshake.
// Optional feature macro: EX_OVERFLOW_TRAP_EN -- when defined, a signed
// overflow on ADD/SUB raises ex_overflow and suppresses the register write.
// When undefined, ex_overflow is tied low and adds/subs simply wrap.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_mem_stage_if.slave bus
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, next_state;

  logic              accept;
  logic              clear_ctrl;
  logic              id_ready;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_result;
  logic              cap_reg_write;
  logic              cap_overflow;

  logic [DATA_W-1:0]     result_q;
  logic                  zero_q;
  logic [DATA_W-1:0]     store_data_q;
  logic [DATA_W-1:0]     branch_target_q;
  logic [REG_ADDR_W-1:0] dest_reg_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  branch_q;
  logic                  overflow_q;

  assign sum  = bus.id_operand_a + bus.id_operand_b;
  assign diff = bus.id_operand_a - bus.id_operand_b;

  // ALU result for the instruction presented by ID/EX; unknown codes give 0
  always_comb begin
    alu_result = '0;
    case (bus.id_alu_ctrl)
      ALU_AND: alu_result = bus.id_operand_a & bus.id_operand_b;
      ALU_OR:  alu_result = bus.id_operand_a | bus.id_operand_b;
      ALU_ADD: alu_result = sum;
      ALU_SUB: alu_result = diff;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}},
                             ($signed(bus.id_operand_a) < $signed(bus.id_operand_b))};
      default: alu_result = '0;
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  logic alu_ovf;

  // Signed overflow detection for ADD/SUB; an overflowing result may not be written back
  always_comb begin
    alu_ovf = 1'b0;
    case (bus.id_alu_ctrl)
      ALU_ADD: alu_ovf = (bus.id_operand_a[DATA_W-1] == bus.id_operand_b[DATA_W-1]) &&
                         (sum[DATA_W-1] != bus.id_operand_a[DATA_W-1]);
      ALU_SUB: alu_ovf = (bus.id_operand_a[DATA_W-1] != bus.id_operand_b[DATA_W-1]) &&
                         (diff[DATA_W-1] != bus.id_operand_a[DATA_W-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  assign cap_reg_write = bus.id_reg_write & ~alu_ovf;
  assign cap_overflow  = alu_ovf;
`else
  assign cap_reg_write = bus.id_reg_write;
  assign cap_overflow  = 1'b0;
`endif

  // A full entry that MEM takes this cycle frees the slot, so refill happens without a bubble
  assign id_ready     = (state == EMPTY) | bus.mem_ready;
  assign bus.id_ready = id_ready;

  // Occupancy register of the EX/MEM slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  // Next occupancy and load/clear decisions; flush beats everything else
  always_comb begin
    next_state = state;
    accept     = bus.id_valid & id_ready & ~bus.id_flush;
    case (state)
      EMPTY: begin
        if (accept) next_state = FULL;
      end
      FULL: begin
        if (bus.id_flush)       next_state = EMPTY;
        else if (accept)        next_state = FULL;
        else if (bus.mem_ready) next_state = EMPTY;
      end
      default: next_state = EMPTY;
    endcase
    clear_ctrl = (next_state == EMPTY);
  end

  // EX/MEM payload: load on accept, drop control bits whenever the slot empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q        <= '0;
      zero_q          <= 1'b0;
      store_data_q    <= '0;
      branch_target_q <= '0;
      dest_reg_q      <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_q        <= 1'b0;
      overflow_q      <= 1'b0;
    end else if (accept) begin
      result_q        <= alu_result;
      zero_q          <= (alu_result == '0);
      store_data_q    <= bus.id_store_data;
      branch_target_q <= bus.id_branch_target;
      dest_reg_q      <= bus.id_dest_reg;
      reg_write_q     <= cap_reg_write;
      mem_read_q      <= bus.id_mem_read;
      mem_write_q     <= bus.id_mem_write;
      branch_q        <= bus.id_branch;
      overflow_q      <= cap_overflow;
    end else if (clear_ctrl) begin
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_q        <= 1'b0;
      overflow_q      <= 1'b0;
    end
  end

  assign bus.ex_valid         = (state == FULL);
  assign bus.ex_result        = result_q;
  assign bus.ex_zero          = zero_q;
  assign bus.ex_store_data    = store_data_q;
  assign bus.ex_branch_target = branch_target_q;
  assign bus.ex_dest_reg      = dest_reg_q;
  assign bus.ex_reg_write     = reg_write_q;
  assign bus.ex_mem_read      = mem_read_q;
  assign bus.ex_mem_write     = mem_write_q;
  assign bus.ex_branch_taken  = (state == FULL) & branch_q & zero_q;
  assign bus.ex_overflow      = overflow_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage.
// Expected overflow/regwrite behaviour follows EX_OVERFLOW_TRAP_EN.
module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

`ifdef EX_OVERFLOW_TRAP_EN
  localparam logic OVF_EXP = 1'b1;
  localparam logic RW_OVF  = 1'b0;
`else
  localparam logic OVF_EXP = 1'b0;
  localparam logic RW_OVF  = 1'b1;
`endif

  ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    bus.id_valid     = v;
    bus.id_alu_ctrl  = c;
    bus.id_operand_a = a;
    bus.id_operand_b = b;
  endtask

  task automatic clearControls();
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.id_mem_write = 1'b0;
    bus.id_branch    = 1'b0;
    bus.id_flush     = 1'b0;
  endtask

  // Directed stimulus sequence
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
    clearControls();
    bus.id_store_data    = '0;
    bus.id_branch_target = '0;
    bus.id_dest_reg      = '0;
    bus.mem_ready        = 1'b1;

    #2;
    checkBit("rst_valid", bus.ex_valid, 1'b0);
    checkBit("rst_ready", bus.id_ready, 1'b1);
    checkOutput("rst_result", bus.ex_result, 32'd0);
    checkOutput("rst_dest", 32'(bus.ex_dest_reg), 32'd0);
    checkBit("rst_taken", bus.ex_branch_taken, 1'b0);
    checkBit("rst_ovf", bus.ex_overflow, 1'b0);
    checkBit("rst_regwrite", bus.ex_reg_write, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // ADD 5+7
    applyStimulus(1'b1, 3'b010, 32'd5, 32'd7);
    bus.id_reg_write = 1'b1;
    bus.id_dest_reg  = 5'd3;
    tick();
    checkBit("add_valid", bus.ex_valid, 1'b1);
    checkOutput("add_result", bus.ex_result, 32'd12);
    checkBit("add_zero", bus.ex_zero, 1'b0);
    checkBit("add_regwrite", bus.ex_reg_write, 1'b1);
    checkOutput("add_dest", 32'(bus.ex_dest_reg), 32'd3);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
    clearControls();
    tick();
    checkBit("add_drain_valid", bus.ex_valid, 1'b0);
    checkBit("add_drain_regwrite", bus.ex_reg_write, 1'b0);

    // BEQ taken: SUB 9-9
    applyStimulus(1'b1, 3'b110, 32'd9, 32'd9);
    bus.id_branch        = 1'b1;
    bus.id_branch_target = 32'h40;
    tick();
    checkOutput("beq_result", bus.ex_result, 32'd0);
    checkBit("beq_zero", bus.ex_zero, 1'b1);
    checkBit("beq_taken", bus.ex_branch_taken, 1'b1);
    checkOutput("beq_target", bus.ex_branch_target, 32'h40);
    // Stall: taken flag must persist
    bus.mem_ready = 1'b0;
    tick();
    checkBit("beq_taken_held", bus.ex_branch_taken, 1'b1);
    bus.mem_ready = 1'b1;
    // BEQ not taken: SUB 9-8 (accepted as the held entry drains)
    applyStimulus(1'b1, 3'b110, 32'd9, 32'd8);
    tick();
    checkOutput("bne_result", bus.ex_result, 32'd1);
    checkBit("bne_taken", bus.ex_branch_taken, 1'b0);
    clearControls();

    // SLT signed, AND, OR, undefined code
    applyStimulus(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("slt_neg_lt", bus.ex_result, 32'd1);
    applyStimulus(1'b1, 3'b111, 32'd1, 32'hFFFF_FFFF);
    tick();
    checkOutput("slt_pos_ge", bus.ex_result, 32'd0);
    applyStimulus(1'b1, 3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    checkOutput("and_result", bus.ex_result, 32'h0000_F000);
    applyStimulus(1'b1, 3'b001, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    checkOutput("or_result", bus.ex_result, 32'h0000_FFF0);
    applyStimulus(1'b1, 3'b011, 32'd3, 32'd4);
    tick();
    checkOutput("undef_result", bus.ex_result, 32'd0);
    checkBit("undef_zero", bus.ex_zero, 1'b1);

    // Backpressure: hold for three cycles, then refill without a bubble
    applyStimulus(1'b1, 3'b010, 32'd1, 32'd2);
    bus.id_dest_reg = 5'd5;
    tick();
    checkOutput("hold_first", bus.ex_result, 32'd3);
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 3'b010, 32'd10, 32'd20);
    bus.id_dest_reg = 5'd6;
    #1;
    checkBit("hold_ready_low", bus.id_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkBit("hold_valid", bus.ex_valid, 1'b1);
      checkOutput("hold_result", bus.ex_result, 32'd3);
      checkOutput("hold_dest", 32'(bus.ex_dest_reg), 32'd5);
      checkBit("hold_ready", bus.id_ready, 1'b0);
    end
    bus.mem_ready = 1'b1;
    #1;
    checkBit("release_ready", bus.id_ready, 1'b1);
    tick();
    checkBit("release_valid", bus.ex_valid, 1'b1);
    checkOutput("release_result", bus.ex_result, 32'd30);
    checkOutput("release_dest", 32'(bus.ex_dest_reg), 32'd6);

    // Flush while an entry is held
    applyStimulus(1'b1, 3'b010, 32'd4, 32'd8);
    bus.id_mem_write = 1'b1;
    bus.id_reg_write = 1'b1;
    tick();
    checkBit("store_memwrite", bus.ex_mem_write, 1'b1);
    bus.mem_ready = 1'b0;
    bus.id_flush  = 1'b1;
    tick();
    checkBit("flush_valid", bus.ex_valid, 1'b0);
    checkBit("flush_memwrite", bus.ex_mem_write, 1'b0);
    checkBit("flush_regwrite", bus.ex_reg_write, 1'b0);
    bus.id_flush  = 1'b0;
    bus.mem_ready = 1'b1;

    // Valid, flush and ready together on a full slot: nothing captured
    tick();
    checkBit("refill_valid", bus.ex_valid, 1'b1);
    bus.id_flush = 1'b1;
    tick();
    checkBit("flush_ready_valid", bus.ex_valid, 1'b0);
    clearControls();

    // Overflow boundaries
    applyStimulus(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);
    bus.id_reg_write = 1'b1;
    tick();
    checkOutput("ovf_add_result", bus.ex_result, 32'h8000_0000);
    checkBit("ovf_add_flag", bus.ex_overflow, OVF_EXP);
    checkBit("ovf_add_regwrite", bus.ex_reg_write, RW_OVF);
    applyStimulus(1'b1, 3'b110, 32'h8000_0000, 32'd1);
    tick();
    checkOutput("ovf_sub_result", bus.ex_result, 32'h7FFF_FFFF);
    checkBit("ovf_sub_flag", bus.ex_overflow, OVF_EXP);
    checkBit("ovf_sub_regwrite", bus.ex_reg_write, RW_OVF);
    applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("wrap_result", bus.ex_result, 32'd0);
    checkBit("wrap_zero", bus.ex_zero, 1'b1);
    checkBit("wrap_flag", bus.ex_overflow, 1'b0);
    checkBit("wrap_regwrite", bus.ex_reg_write, 1'b1);

    // Asynchronous reset mid-operation, then accept on the first edge after release
    applyStimulus(1'b1, 3'b001, 32'h0000_0100, 32'h0000_0001);
    tick();
    checkOutput("pre_rst_result", bus.ex_result, 32'h0000_0101);
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("async_rst_valid", bus.ex_valid, 1'b0);
    checkOutput("async_rst_result", bus.ex_result, 32'd0);
    checkBit("async_rst_regwrite", bus.ex_reg_write, 1'b0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'b010, 32'd20, 32'd22);
    tick();
    checkBit("post_rst_valid", bus.ex_valid, 1'b1);
    checkOutput("post_rst_result", bus.ex_result, 32'd42);

    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
    clearControls();
    tick();
    checkBit("final_drain", bus.ex_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
